// File: rtl/motor_cycle_monitor.sv
// ----------------------------------------------------------------------------
// motor_cycle_monitor
//
// Passive checker that sits beside the motor-controller FSM and watches its
// outputs (M1 drive, M2 drive, in-cycle flag). Every motor phase is timed in
// milliseconds and compared against the expected phase length. Completed
// M1 -> M2 -> M1 cycles are counted. Any protocol violation latches a sticky
// fault code that holds until clear or reset.
//
// Optional feature macro: MOTOR_MON_MAXPHASE_EN
//   defined   : max_phase_ms tracks the longest checked phase
//   undefined : max_phase_ms is tied to 0; no register or comparator is built
//
// Parameters
//   F_CLK_HZ     clock frequency; one ms tick every F_CLK_HZ/1000 cycles
//   NORMAL_SECS  expected phase length with test_mode = 0
//   TEST_SECS    expected phase length with test_mode = 1
//   TOL_MS       allowed +/- deviation of a completed phase, in ms
//   CNT_W        width of cycle_count
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   m1_in          in   motor 1 drive (asynchronous)
//   m2_in          in   motor 2 drive (asynchronous)
//   cyc_in         in   in-cycle flag (asynchronous)
//   test_mode      in   expected-length select (asynchronous level)
//   clear          in   synchronous one-cycle pulse; clears fault and counters
//   phase_ok       out  one-cycle pulse when a phase ends within tolerance
//   fault          out  sticky fault flag
//   fault_code     out  0 none, 1 overlap, 2 order, 3 short/long,
//                       4 overrun, 5 cyc mismatch
//   cycle_count    out  completed M1+M2 cycles (wraps)
//   last_phase_ms  out  duration of the last completed or aborted phase
//   max_phase_ms   out  longest checked phase (optional, else 0)
//
// States
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no phase running; waiting for a clean M1 rising edge
//   ST_PH_M1 | M1 phase running, timer active
//   ST_PH_M2 | M2 phase running, timer active
//   ST_FAULT | violation latched; monitoring stopped until clear/reset
// ----------------------------------------------------------------------------
module motor_cycle_monitor #(
    parameter int F_CLK_HZ    = 25_000_000,
    parameter int NORMAL_SECS = 30,
    parameter int TEST_SECS   = 3,
    parameter int TOL_MS      = 20,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m1_in,
    input  logic             m2_in,
    input  logic             cyc_in,
    input  logic             test_mode,
    input  logic             clear,
    output logic             phase_ok,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [16:0]      last_phase_ms,
    output logic [16:0]      max_phase_ms
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PH_M1 = 2'd1,
        ST_PH_M2 = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int MS_W  = 17;
    localparam int DIV   = F_CLK_HZ / 1000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
    localparam logic [MS_W-1:0]  MS_SAT     = '1;
    localparam logic [MS_W-1:0]  EXP_NORMAL = MS_W'(NORMAL_SECS * 1000);
    localparam logic [MS_W-1:0]  EXP_TEST   = MS_W'(TEST_SECS * 1000);
    localparam logic [MS_W:0]    TOL        = (MS_W + 1)'(TOL_MS);

    localparam logic [2:0] FC_OVERLAP  = 3'd1;
    localparam logic [2:0] FC_ORDER    = 3'd2;
    localparam logic [2:0] FC_DURATION = 3'd3;
    localparam logic [2:0] FC_OVERRUN  = 3'd4;
    localparam logic [2:0] FC_MISMATCH = 3'd5;

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 = m1, 1 = m2, 2 = cyc, 3 = test_mode.
    // Only the motor drives need an edge-detect copy.
    // ------------------------------------------------------------------
    logic [3:0] r_meta;
    logic [3:0] r_sync;
    logic [1:0] r_dly;

    logic w_m1;
    logic w_m2;
    logic w_cyc;
    logic w_tm;
    logic w_m1_rise;
    logic w_m1_fall;
    logic w_m2_rise;
    logic w_m2_fall;

    assign w_m1      = r_sync[0];
    assign w_m2      = r_sync[1];
    assign w_cyc     = r_sync[2];
    assign w_tm      = r_sync[3];
    assign w_m1_rise =  r_sync[0] & ~r_dly[0];
    assign w_m1_fall = ~r_sync[0] &  r_dly[0];
    assign w_m2_rise =  r_sync[1] & ~r_dly[1];
    assign w_m2_fall = ~r_sync[1] &  r_dly[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_dly  <= '0;
        end else begin
            r_meta <= {test_mode, cyc_in, m2_in, m1_in};
            r_sync <= r_meta;
            r_dly  <= r_sync[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [PRE_W-1:0] r_presc;
    logic [MS_W-1:0]  r_ms;
    logic [MS_W-1:0]  r_exp_ms;
    logic             r_phase_ok;
    logic             r_fault;
    logic [2:0]       r_fault_code;
    logic [CNT_W-1:0] r_cycle_count;
    logic [MS_W-1:0]  r_last_ms;

    // ------------------------------------------------------------------
    // Phase timer. w_ms_now already includes a tick landing on this edge,
    // so a phase spanning N*DIV cycles between decision edges measures N ms.
    // ------------------------------------------------------------------
    logic            w_tick;
    logic [MS_W-1:0] w_ms_now;
    logic [MS_W-1:0] w_exp_sel;
    logic            w_in_tol;
    logic            w_overrun;

    assign w_tick    = (r_presc == PRE_LAST);
    assign w_ms_now  = (w_tick && (r_ms != MS_SAT)) ? r_ms + MS_W'(1) : r_ms;
    assign w_exp_sel = w_tm ? EXP_TEST : EXP_NORMAL;

    // 18-bit compares so exp_ms - TOL can never underflow
    assign w_in_tol  = (({1'b0, w_ms_now} + TOL) >= {1'b0, r_exp_ms}) &&
                       ({1'b0, w_ms_now} <= ({1'b0, r_exp_ms} + TOL));
    assign w_overrun = {1'b0, w_ms_now} > ({1'b0, r_exp_ms} + TOL);

    // ------------------------------------------------------------------
    // Next-state / decision logic. The if/else chain encodes event priority:
    // overlap > mismatch > order > short/long > overrun > normal moves.
    // ------------------------------------------------------------------
    state_t     w_state_nxt;
    logic       w_fault_req;
    logic [2:0] w_code_req;
    logic       w_phase_ok_nxt;
    logic       w_load_last;
    logic       w_timer_start;
    logic       w_cnt_inc;

    always_comb begin
        w_state_nxt    = r_state;
        w_fault_req    = 1'b0;
        w_code_req     = 3'd0;
        w_phase_ok_nxt = 1'b0;
        w_load_last    = 1'b0;
        w_timer_start  = 1'b0;
        w_cnt_inc      = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state != ST_FAULT) begin
            if (w_m1 && w_m2) begin
                w_fault_req = 1'b1;
                w_code_req  = FC_OVERLAP;
            end else if ((w_m1 || w_m2) != w_cyc) begin
                w_fault_req = 1'b1;
                w_code_req  = FC_MISMATCH;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_m2_rise && !w_m1) begin
                            w_fault_req = 1'b1;
                            w_code_req  = FC_ORDER;
                        end else if (w_m1_rise && !w_m2) begin
                            w_state_nxt   = ST_PH_M1;
                            w_timer_start = 1'b1;
                        end
                    end
                    ST_PH_M1: begin
                        if (w_m1_fall && w_m2_rise) begin
                            w_load_last = 1'b1;
                            if (w_in_tol) begin
                                w_state_nxt    = ST_PH_M2;
                                w_phase_ok_nxt = 1'b1;
                                w_timer_start  = 1'b1;
                            end else begin
                                w_fault_req = 1'b1;
                                w_code_req  = FC_DURATION;
                            end
                        end else if (w_m1_fall) begin
                            w_state_nxt = ST_IDLE;
                            w_load_last = 1'b1;
                        end else if (w_overrun) begin
                            w_fault_req = 1'b1;
                            w_code_req  = FC_OVERRUN;
                        end
                    end
                    ST_PH_M2: begin
                        if (w_m2_fall && w_m1_rise) begin
                            w_load_last = 1'b1;
                            if (w_in_tol) begin
                                w_state_nxt    = ST_PH_M1;
                                w_phase_ok_nxt = 1'b1;
                                w_timer_start  = 1'b1;
                                w_cnt_inc      = 1'b1;
                            end else begin
                                w_fault_req = 1'b1;
                                w_code_req  = FC_DURATION;
                            end
                        end else if (w_m2_fall) begin
                            w_state_nxt = ST_IDLE;
                            w_load_last = 1'b1;
                        end else if (w_overrun) begin
                            w_fault_req = 1'b1;
                            w_code_req  = FC_OVERRUN;
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end

            if (w_fault_req) begin
                w_state_nxt = ST_FAULT;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_phase_ok    <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= 3'd0;
            r_cycle_count <= '0;
            r_last_ms     <= '0;
        end else if (clear) begin
            r_state       <= ST_IDLE;
            r_phase_ok    <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= 3'd0;
            r_cycle_count <= '0;
            r_last_ms     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase_ok <= w_phase_ok_nxt;
            if (w_fault_req) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_code_req;
            end
            if (w_load_last) begin
                r_last_ms <= w_ms_now;
            end
            if (w_cnt_inc) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

    // Phase timer; exp_ms is captured at every phase start so a test_mode
    // change mid-phase only affects the next phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_ms     <= '0;
            r_exp_ms <= '0;
        end else if (w_timer_start) begin
            r_presc  <= '0;
            r_ms     <= '0;
            r_exp_ms <= w_exp_sel;
        end else if ((r_state == ST_PH_M1) || (r_state == ST_PH_M2)) begin
            r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
            r_ms    <= w_ms_now;
        end
    end

`ifdef MOTOR_MON_MAXPHASE_EN
    // A load that does not return to IDLE is a checked handover (pass or fail).
    logic [MS_W-1:0] r_max_ms;
    logic            w_max_upd;

    assign w_max_upd = w_load_last && (w_state_nxt != ST_IDLE) &&
                       (w_ms_now > r_max_ms);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_ms <= '0;
        end else if (clear) begin
            r_max_ms <= '0;
        end else if (w_max_upd) begin
            r_max_ms <= w_ms_now;
        end
    end

    assign max_phase_ms = r_max_ms;
`else
    assign max_phase_ms = '0;
`endif

    assign phase_ok      = r_phase_ok;
    assign fault         = r_fault;
    assign fault_code    = r_fault_code;
    assign cycle_count   = r_cycle_count;
    assign last_phase_ms = r_last_ms;

endmodule
